vec_wb_merge: RTL
=================

Name: vec_wb_merge

Overview:
- Downstream stage of the vector ALU lanes.
- Drives `lane_run` to the lanes and captures each lane's `vd` when that lane asserts `done`.
- Merges the interleaved lane results element by element (element e comes from lane e mod 2^nb_lanes), applying vstart, vl and the v0 mask with undisturbed policy.
- Writes one merged VLEN-bit result to the vector register file through a valid/ready write port.

Parameters:
- VLEN, 128, vector register width in bits; power of two, at most 512.
- MAX_LANES, 4, number of physical lane inputs; nb_lanes selects how many are used.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to begin an operation; sampled only in IDLE.
- nb_lanes  in  2  2^nb_lanes lanes in use (must be ≤ MAX_LANES); sampled on start.
- vsew  in  3  element width 8<<vsew (000..011); sampled on start.
- vl  in  11  active element count; sampled on start.
- vstart  in  11  first active element; sampled on start.
- vm  in  1  1 = unmasked, 0 = use v0_mask; sampled on start.
- v0_mask  in  VLEN  mask register; bit e gates element e; sampled on start.
- old_vd  in  VLEN  prior destination contents; sampled on start.
- vd_addr  in  5  destination register number; sampled on start.
- lane_vd  in  MAX_LANES*VLEN  lane i result at [i*VLEN +: VLEN].
- lane_done  in  MAX_LANES  per-lane done level.
- lane_run  out  1  run to the lanes.
- wr_valid  out  1  write request.
- wr_ready  in  1  register file accepts the write.
- wr_addr  out  5  write register number.
- wr_data  out  VLEN  merged write data.
- busy  out  1  high in any state except IDLE.
- done  out  1  one-cycle pulse after the write handshake.

Behaviour:
- Reset, synchronous:
  - state = IDLE.
  - lane_run, wr_valid, done, busy = 0.
  - wr_addr, wr_data, capture registers and captured flags = 0.
  - Reset mid-operation aborts immediately with no write. lane_run drops the next cycle, which clears the lanes.
- FSM states: IDLE, COLLECT, MERGE, WRITE, FIN.
- IDLE:
  - On start, latch all sampled inputs, clear captured flags and go to COLLECT.
  - lane_run = 1 from the next cycle.
- COLLECT:
  - For each lane i < 2^nb_lanes: if lane_done[i] && !captured[i], capture lane_vd[i] and set captured[i].
  - Lanes at or above 2^nb_lanes are treated as captured and ignored.
  - When all used lanes are captured (including captures made this cycle), go to MERGE and drop lane_run in the same edge.
- MERGE, one cycle, registers wr_data. For each element e < VLEN>>(vsew+3):
  - active = (e ≥ vstart) && (e < vl) && (vm || v0_mask[e]).
  - Active element: data = cap[e mod 2^nb_lanes] element e.
  - Inactive element: data = old_vd element e.
  - If vl > VLEN>>(vsew+3), clamp vl to that value.
  - If vstart ≥ vl, no element is active and wr_data = old_vd.
  - Go to WRITE.
- WRITE:
  - wr_valid = 1; wr_addr and wr_data stay stable until wr_ready.
  - On wr_valid && wr_ready, drop wr_valid and go to FIN.
  - wr_ready high on the first WRITE cycle gives a one-cycle handshake.
- FIN: done = 1 for one cycle, then IDLE.
- start outside IDLE is ignored.
- Latency from start to wr_valid is 1 + (COLLECT cycles) + 1, where COLLECT cycles is the time until the last lane_done.
- A lane_done seen on the same edge that COLLECT is entered is not captured. Capture only happens while in COLLECT with lane_run = 1.

Decomposition:
- Shared package `vec_pkg`:
  - SEW encodings (SEW8..SEW64).
  - FSM state localparams.
  - Helper constant function elems(vsew, VLEN).
- One natural sub-module, `vec_elem_select`: the purely combinational per-element select/mask merge used in MERGE, parameterised by VLEN and MAX_LANES.

Test Plan:
- Four lanes, vsew=000, vl=16, vm=1, vstart=0; lane i returns bytes 0x10·i+e in its owned slots; lane_done asserted on staggered cycles 3,5,4,7 → lane_run drops after the cycle-7 capture; wr_data byte e = 0x10·(e mod 4)+e; done pulse follows the handshake.
- Same as above but vl=5, old_vd all 0xAA → bytes 0..4 merged from lanes, bytes 5..15 = 0xAA.
- vm=0, v0_mask=16'h00F0, vsew=000, one lane (nb_lanes=0) all 0x55, old_vd=0 → bytes 4..7 = 0x55, all other bytes 0.
- vsew=010, two lanes, vstart=2, vl=4 → 32-bit words 2 and 3 merged from lanes 0 and 1, words 0 and 1 = old_vd.
- wr_ready held low for 5 cycles → wr_valid, wr_addr and wr_data stay stable; done pulses exactly once, one cycle after the handshake.
- reset asserted in COLLECT with 2 of 4 lanes captured → next cycle IDLE, lane_run=0, wr_valid=0, no done; a new start afterwards completes normally.

Source files
------------

// File: rtl/vec_pkg.sv
// Shared definitions for the vector write-back merge stage: SEW codes,
// FSM states and the element-count helper.
package vec_pkg;

    typedef enum logic [2:0] {
        SEW8  = 3'b000,
        SEW16 = 3'b001,
        SEW32 = 3'b010,
        SEW64 = 3'b011
    } sew_e;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_COLLECT = 3'd1,
        ST_MERGE   = 3'd2,
        ST_WRITE   = 3'd3,
        ST_FIN     = 3'd4
    } state_e;

    // Number of elements of width 8<<vsew that fit in one vlen-bit register.
    function automatic int elems(input logic [2:0] vsew, input int vlen);
        return vlen >> (int'(vsew[1:0]) + 3);
    endfunction

endpackage

// File: rtl/vec_elem_select.sv
// Combinational per-element merge: picks each element from its owning lane
// capture or from the old destination, under vstart, vl and the v0 mask.
module vec_elem_select
    import vec_pkg::*;
#(
    parameter int VLEN      = 128,
    parameter int MAX_LANES = 4
) (
    input  logic [1:0]                nb_lanes,
    input  logic [2:0]                vsew,
    input  logic [10:0]               vl,
    input  logic [10:0]               vstart,
    input  logic                      vm,
    input  logic [VLEN-1:0]           v0_mask,
    input  logic [VLEN-1:0]           old_vd,
    input  logic [MAX_LANES*VLEN-1:0] cap,
    output logic [VLEN-1:0]           merged
);

    localparam int NBYTES = VLEN / 8;
    localparam int MW     = $clog2(VLEN);
    localparam int LW     = $clog2(MAX_LANES);

    logic [10:0]   vl_eff;
    logic [10:0]   e_idx;
    logic [LW-1:0] lane_mask;
    logic [LW-1:0] lane;
    logic          act;

    // Work byte by byte; each byte belongs to element (byte >> vsew), so one
    // loop covers every element width without a per-SEW case.
    always_comb begin
        vl_eff    = vl;
        e_idx     = '0;
        lane      = '0;
        act       = 1'b0;
        merged    = old_vd;
        lane_mask = LW'((32'd1 << nb_lanes) - 32'd1);
        if (vl > 11'(elems(vsew, VLEN))) begin
            vl_eff = 11'(elems(vsew, VLEN));
        end
        for (int b = 0; b < NBYTES; b++) begin
            e_idx = 11'(b >> vsew[1:0]);
            lane  = e_idx[LW-1:0] & lane_mask;
            act   = (e_idx >= vstart) && (e_idx < vl_eff) &&
                    (vm || v0_mask[e_idx[MW-1:0]]);
            if (act) begin
                merged[b*8 +: 8] = cap[int'(lane)*VLEN + b*8 +: 8];
            end
        end
    end

endmodule

// File: rtl/vec_wb_merge.sv
// Vector write-back merge: runs the lanes, captures each lane's result on its
// done, merges the interleaved elements and writes one register to the VRF.
module vec_wb_merge
    import vec_pkg::*;
#(
    parameter int VLEN      = 128,
    parameter int MAX_LANES = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [1:0]                nb_lanes,
    input  logic [2:0]                vsew,
    input  logic [10:0]               vl,
    input  logic [10:0]               vstart,
    input  logic                      vm,
    input  logic [VLEN-1:0]           v0_mask,
    input  logic [VLEN-1:0]           old_vd,
    input  logic [4:0]                vd_addr,
    input  logic [MAX_LANES*VLEN-1:0] lane_vd,
    input  logic [MAX_LANES-1:0]      lane_done,
    output logic                      lane_run,
    output logic                      wr_valid,
    input  logic                      wr_ready,
    output logic [4:0]                wr_addr,
    output logic [VLEN-1:0]           wr_data,
    output logic                      busy,
    output logic                      done
);

    state_e                    state_q, state_d;
    logic [1:0]                nb_q, nb_d;
    logic [2:0]                sew_q, sew_d;
    logic [10:0]               vl_q, vl_d;
    logic [10:0]               vstart_q, vstart_d;
    logic                      vm_q, vm_d;
    logic [VLEN-1:0]           mask_q, mask_d;
    logic [VLEN-1:0]           old_q, old_d;
    logic [4:0]                addr_q, addr_d;
    logic [MAX_LANES*VLEN-1:0] cap_q, cap_d;
    logic [MAX_LANES-1:0]      capd_q, capd_d;
    logic                      run_q, run_d;
    logic                      valid_q, valid_d;
    logic [VLEN-1:0]           data_q, data_d;
    logic                      done_q, done_d;
    logic [MAX_LANES-1:0]      used;
    logic [VLEN-1:0]           merged;

    vec_elem_select #(
        .VLEN      (VLEN),
        .MAX_LANES (MAX_LANES)
    ) u_sel (
        .nb_lanes (nb_q),
        .vsew     (sew_q),
        .vl       (vl_q),
        .vstart   (vstart_q),
        .vm       (vm_q),
        .v0_mask  (mask_q),
        .old_vd   (old_q),
        .cap      (cap_q),
        .merged   (merged)
    );

    always_comb begin
        state_d  = state_q;
        nb_d     = nb_q;
        sew_d    = sew_q;
        vl_d     = vl_q;
        vstart_d = vstart_q;
        vm_d     = vm_q;
        mask_d   = mask_q;
        old_d    = old_q;
        addr_d   = addr_q;
        cap_d    = cap_q;
        capd_d   = capd_q;
        run_d    = run_q;
        valid_d  = valid_q;
        data_d   = data_q;
        done_d   = 1'b0;
        for (int i = 0; i < MAX_LANES; i++) begin
            used[i] = (i < (32'd1 << nb_q));
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    nb_d     = nb_lanes;
                    sew_d    = vsew;
                    vl_d     = vl;
                    vstart_d = vstart;
                    vm_d     = vm;
                    mask_d   = v0_mask;
                    old_d    = old_vd;
                    addr_d   = vd_addr;
                    capd_d   = '0;
                    run_d    = 1'b1;
                    state_d  = ST_COLLECT;
                end
            end
            ST_COLLECT: begin
                for (int i = 0; i < MAX_LANES; i++) begin
                    if (run_q && used[i] && lane_done[i] && !capd_q[i]) begin
                        cap_d[i*VLEN +: VLEN] = lane_vd[i*VLEN +: VLEN];
                        capd_d[i]             = 1'b1;
                    end
                end
                // Unused lanes count as captured so only real lanes gate the exit.
                if (&(capd_d | ~used)) begin
                    run_d   = 1'b0;
                    state_d = ST_MERGE;
                end
            end
            ST_MERGE: begin
                data_d  = merged;
                valid_d = 1'b1;
                state_d = ST_WRITE;
            end
            ST_WRITE: begin
                if (valid_q && wr_ready) begin
                    valid_d = 1'b0;
                    done_d  = 1'b1;
                    state_d = ST_FIN;
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            nb_q     <= '0;
            sew_q    <= '0;
            vl_q     <= '0;
            vstart_q <= '0;
            vm_q     <= 1'b0;
            mask_q   <= '0;
            old_q    <= '0;
            addr_q   <= '0;
            cap_q    <= '0;
            capd_q   <= '0;
            run_q    <= 1'b0;
            valid_q  <= 1'b0;
            data_q   <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            nb_q     <= nb_d;
            sew_q    <= sew_d;
            vl_q     <= vl_d;
            vstart_q <= vstart_d;
            vm_q     <= vm_d;
            mask_q   <= mask_d;
            old_q    <= old_d;
            addr_q   <= addr_d;
            cap_q    <= cap_d;
            capd_q   <= capd_d;
            run_q    <= run_d;
            valid_q  <= valid_d;
            data_q   <= data_d;
            done_q   <= done_d;
        end
    end

    assign lane_run = run_q;
    assign wr_valid = valid_q;
    assign wr_addr  = addr_q;
    assign wr_data  = data_q;
    assign done     = done_q;
    assign busy     = (state_q != ST_IDLE);

endmodule
